tinker_exec_sequencer: RTL and testbench

- Multi-cycle control FSM that accepts one Tinker instruction at a time and sequences the datapath: register-file read, dispatch, write-back.
- Dispatch goes to the combinational integer ALU (single cycle) or the shared FPU (variable latency, valid/ready handshake).
- Sits between the instruction source in tinker_core and the regFile/alu/fpu datapath, and owns the only register-file write port.

---
 rtl/tinker_exec_sequencer.sv | 159 +++++++++++++++
 tb/tb_tinker_exec_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_exec_sequencer.sv
// Tinker execution sequencer: accepts one instruction at a time and walks it
// through register read, ALU or FPU dispatch, and register-file write-back.
module tinker_exec_sequencer #(
   parameter int unsigned FPU_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [31:0]      instr,
   output logic             rf_re,
   output logic [4:0]       rf_rs_addr,
   output logic [4:0]       rf_rt_addr,
   input  logic [63:0]      rf_rs_data,
   input  logic [63:0]      rf_rt_data,
   output logic [4:0]       alu_op,
   output logic [63:0]      alu_a,
   output logic [63:0]      alu_b,
   output logic [11:0]      alu_L,
   input  logic [63:0]      alu_result,
   output logic             fpu_req_valid,
   input  logic             fpu_req_ready,
   output logic [4:0]       fpu_op,
   output logic [63:0]      fpu_a,
   output logic [63:0]      fpu_b,
   input  logic             fpu_resp_valid,
   input  logic [63:0]      fpu_result,
   output logic             rf_we,
   output logic [4:0]       rf_wa,
   output logic [63:0]      rf_wd,
   output logic             busy,
   output logic             illegal_op,
   output logic             fpu_timeout,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_ALU   = 3'd2;
   localparam logic [2:0] S_FREQ  = 3'd3;
   localparam logic [2:0] S_FWAIT = 3'd4;
   localparam logic [2:0] S_WB    = 3'd5;

   localparam int unsigned       WAIT_W    = (FPU_TIMEOUT > 1) ? $clog2(FPU_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FPU_TIMEOUT - 1);

   logic [2:0]        r_state;
   logic [4:0]        r_op;
   logic [4:0]        r_rd;
   logic [4:0]        r_rs;
   logic [4:0]        r_rt;
   logic [11:0]       r_L;
   logic [63:0]       r_opA;
   logic [63:0]       r_opB;
   logic [63:0]       r_res;
   logic [WAIT_W-1:0] r_wait;
   logic              r_timeout;
   logic [CNT_W-1:0]  r_retired;

   logic w_is_alu;
   logic w_is_fpu;

   always_comb begin
      w_is_alu = 1'b0;
      case (r_op)
         5'b11000, 5'b11010, 5'b11100, 5'b11101,
         5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
         5'b00110, 5'b10001, 5'b10010: w_is_alu = 1'b1;
         default:                      w_is_alu = 1'b0;
      endcase
      w_is_fpu = (r_op[4:2] == 3'b101);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_rd      <= '0;
         r_rs      <= '0;
         r_rt      <= '0;
         r_L       <= '0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_res     <= '0;
         r_wait    <= '0;
         r_timeout <= 1'b0;
         r_retired <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_op    <= instr[31:27];
                  r_rd    <= instr[26:22];
                  r_rs    <= instr[21:17];
                  r_rt    <= instr[16:12];
                  r_L     <= instr[11:0];
                  r_state <= S_READ;
               end
            end
            S_READ: begin
               r_opA <= rf_rs_data;
               r_opB <= rf_rt_data;
               if (w_is_alu)      r_state <= S_ALU;
               else if (w_is_fpu) r_state <= S_FREQ;
               else               r_state <= S_IDLE;
            end
            S_ALU: begin
               r_res   <= alu_result;
               r_state <= S_WB;
            end
            S_FREQ: begin
               if (fpu_req_ready) begin
                  r_wait  <= '0;
                  r_state <= S_FWAIT;
               end
            end
            S_FWAIT: begin
               // A response in the final wait cycle still beats the timeout.
               if (fpu_resp_valid) begin
                  r_res   <= fpu_result;
                  r_state <= S_WB;
               end else if (r_wait == WAIT_LAST) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end
            S_WB: begin
               r_retired <= r_retired + CNT_W'(1);
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign instr_ready   = (r_state == S_IDLE);
   assign busy          = (r_state != S_IDLE);
   assign rf_re         = (r_state == S_READ);
   assign rf_rs_addr    = r_rs;
   assign rf_rt_addr    = r_rt;
   assign alu_op        = r_op;
   assign alu_a         = r_opA;
   assign alu_b         = r_opB;
   assign alu_L         = r_L;
   assign fpu_req_valid = (r_state == S_FREQ);
   assign fpu_op        = r_op;
   assign fpu_a         = r_opA;
   assign fpu_b         = r_opB;
   assign rf_we         = (r_state == S_WB);
   assign rf_wa         = r_rd;
   assign rf_wd         = r_res;
   assign illegal_op    = (r_state == S_READ) && !w_is_alu && !w_is_fpu;
   assign fpu_timeout   = r_timeout;
   assign retired       = r_retired;

endmodule

// File: tb/tb_tinker_exec_sequencer.sv
// Directed bench for tinker_exec_sequencer with a behavioural register file and ALU.
module tb_tinker_exec_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        rf_re;
   logic [4:0]  rf_rs_addr, rf_rt_addr;
   logic [63:0] rf_rs_data, rf_rt_data;
   logic [4:0]  alu_op;
   logic [63:0] alu_a, alu_b;
   logic [11:0] alu_L;
   logic [63:0] alu_result;
   logic        fpu_req_valid, fpu_req_ready;
   logic [4:0]  fpu_op;
   logic [63:0] fpu_a, fpu_b;
   logic        fpu_resp_valid;
   logic [63:0] fpu_result;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [63:0] rf_wd;
   logic        busy, illegal_op, fpu_timeout;
   logic [1:0]  retired;

   logic [63:0] regs [32];
   int          nerr   = 0;
   int          nchk   = 0;
   int          we_cnt = 0;
   int          fq_cnt = 0;
   int          we_base, fq_base;

   tinker_exec_sequencer #(.FPU_TIMEOUT(4), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .rf_re(rf_re), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
      .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .alu_op(alu_op), .alu_a(alu_a),
      .alu_b(alu_b), .alu_L(alu_L), .alu_result(alu_result), .fpu_req_valid(fpu_req_valid),
      .fpu_req_ready(fpu_req_ready), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_resp_valid(fpu_resp_valid), .fpu_result(fpu_result), .rf_we(rf_we),
      .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy), .illegal_op(illegal_op),
      .fpu_timeout(fpu_timeout), .retired(retired)
   );

   always #5 clk = ~clk;

   assign rf_rs_data = regs[rf_rs_addr];
   assign rf_rt_data = regs[rf_rt_addr];
   // mov places the literal in bits 63:52; everything else used here is add.
   assign alu_result = (alu_op == 5'b10010) ? {alu_L, alu_a[51:0]} : alu_a + alu_b;

   always @(posedge clk) if (rf_we) regs[rf_wa] <= rf_wd;

   always @(negedge clk) begin
      if (rf_we)         we_cnt <= we_cnt + 1;
      if (fpu_req_valid) fq_cnt <= fq_cnt + 1;
   end

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [11:0] lit);
      return {op, rd, rs, rt, lit};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] w);
      instr       = w;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = '0;
      rst_n          = 1'b0;
      instr_valid    = 1'b0;
      instr          = '0;
      fpu_req_ready  = 1'b0;
      fpu_resp_valid = 1'b0;
      fpu_result     = '0;
      #1;
      chk("rst_ready",   64'(instr_ready), 64'd1);
      chk("rst_busy",    64'(busy), 64'd0);
      chk("rst_we",      64'(rf_we), 64'd0);
      chk("rst_re",      64'(rf_re), 64'd0);
      chk("rst_fqv",     64'(fpu_req_valid), 64'd0);
      chk("rst_wd",      rf_wd, 64'd0);
      chk("rst_retired", 64'(retired), 64'd0);
      chk("rst_tmo",     64'(fpu_timeout), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      regs[1] = 64'd5;
      regs[2] = 64'd7;

      // add r3 = r1 + r2
      issue(mk(5'b11000, 5'd3, 5'd1, 5'd2, 12'd0));
      chk("add_re",   64'(rf_re), 64'd1);
      chk("add_rsa",  64'(rf_rs_addr), 64'd1);
      chk("add_rta",  64'(rf_rt_addr), 64'd2);
      chk("add_we1",  64'(rf_we), 64'd0);
      tick();
      chk("add_a",    alu_a, 64'd5);
      chk("add_b",    alu_b, 64'd7);
      chk("add_we2",  64'(rf_we), 64'd0);
      tick();
      chk("add_we3",  64'(rf_we), 64'd1);
      chk("add_wa",   64'(rf_wa), 64'd3);
      chk("add_wd",   rf_wd, 64'd12);
      tick();
      chk("add_we4",  64'(rf_we), 64'd0);
      chk("add_rdy4", 64'(instr_ready), 64'd1);
      chk("add_ret",  64'(retired), 64'd1);
      chk("add_r3",   regs[3], 64'd12);

      // mov r4, 0xABC
      fq_base = fq_cnt;
      issue(mk(5'b10010, 5'd4, 5'd4, 5'd0, 12'hABC));
      tick(); tick();
      chk("mov_we",   64'(rf_we), 64'd1);
      chk("mov_wa",   64'(rf_wa), 64'd4);
      chk("mov_wd",   rf_wd, 64'hABC0_0000_0000_0000);
      tick();
      chk("mov_ret",  64'(retired), 64'd2);
      chk("mov_nofpu", 64'(fq_cnt - fq_base), 64'd0);

      // addf r7 = 1.5 + 2.25 with request stall and delayed response
      regs[5] = $realtobits(1.5);
      regs[6] = $realtobits(2.25);
      issue(mk(5'b10100, 5'd7, 5'd5, 5'd6, 12'd0));
      tick();
      chk("f_qv1",  64'(fpu_req_valid), 64'd1);
      chk("f_a1",   fpu_a, $realtobits(1.5));
      chk("f_b1",   fpu_b, $realtobits(2.25));
      chk("f_op1",  64'(fpu_op), 64'h14);
      tick();
      chk("f_qv2",  64'(fpu_req_valid), 64'd1);
      chk("f_a2",   fpu_a, $realtobits(1.5));
      chk("f_b2",   fpu_b, $realtobits(2.25));
      fpu_req_ready = 1'b1;
      tick();
      fpu_req_ready = 1'b0;
      chk("f_qv3",  64'(fpu_req_valid), 64'd0);
      chk("f_busy", 64'(busy), 64'd1);
      tick(); tick();
      chk("f_busy2", 64'(busy), 64'd1);
      chk("f_we0",  64'(rf_we), 64'd0);
      fpu_resp_valid = 1'b1;
      fpu_result     = $realtobits(3.75);
      tick();
      fpu_resp_valid = 1'b0;
      chk("f_we",   64'(rf_we), 64'd1);
      chk("f_wa",   64'(rf_wa), 64'd7);
      chk("f_wd",   rf_wd, $realtobits(3.75));
      tick();
      chk("f_ret",  64'(retired), 64'd3);
      chk("f_idle", 64'(busy), 64'd0);

      // illegal opcode 01111
      we_base = we_cnt;
      issue(mk(5'b01111, 5'd8, 5'd1, 5'd2, 12'd0));
      chk("ill_pulse", 64'(illegal_op), 64'd1);
      tick();
      chk("ill_clear", 64'(illegal_op), 64'd0);
      chk("ill_rdy",   64'(instr_ready), 64'd1);
      chk("ill_ret",   64'(retired), 64'd3);
      chk("ill_nowe",  64'(we_cnt - we_base), 64'd0);

      // FPU timeout after 4 wait cycles, then a late response
      fpu_req_ready = 1'b1;
      issue(mk(5'b10101, 5'd8, 5'd5, 5'd6, 12'd0));
      tick();
      tick();
      fpu_req_ready = 1'b0;
      tick(); tick(); tick();
      chk("to_busy", 64'(busy), 64'd1);
      chk("to_flag0", 64'(fpu_timeout), 64'd0);
      tick();
      chk("to_flag", 64'(fpu_timeout), 64'd1);
      chk("to_idle", 64'(busy), 64'd0);
      fpu_resp_valid = 1'b1;
      fpu_result     = 64'hDEAD;
      tick();
      fpu_resp_valid = 1'b0;
      chk("to_late_busy", 64'(busy), 64'd0);
      chk("to_nowe",  64'(we_cnt - we_base), 64'd0);
      chk("to_ret",   64'(retired), 64'd3);
      issue(mk(5'b11000, 5'd9, 5'd1, 5'd2, 12'd0));
      tick(); tick();
      chk("to_add_wd", rf_wd, 64'd12);
      chk("to_add_wa", 64'(rf_wa), 64'd9);
      tick();
      chk("to_wrap",   64'(retired), 64'd0);
      chk("to_sticky", 64'(fpu_timeout), 64'd1);

      // reset in F_WAIT, response arriving around the reset
      fpu_req_ready = 1'b1;
      issue(mk(5'b10100, 5'd10, 5'd5, 5'd6, 12'd0));
      tick();
      tick();
      fpu_req_ready = 1'b0;
      tick();
      we_base = we_cnt;
      rst_n          = 1'b0;
      fpu_resp_valid = 1'b1;
      fpu_result     = 64'hBEEF;
      #1;
      chk("mr_busy",  64'(busy), 64'd0);
      chk("mr_rdy",   64'(instr_ready), 64'd1);
      chk("mr_tmo",   64'(fpu_timeout), 64'd0);
      chk("mr_ret",   64'(retired), 64'd0);
      chk("mr_we",    64'(rf_we), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      fpu_resp_valid = 1'b0;
      chk("mr_busy2", 64'(busy), 64'd0);
      chk("mr_nowe",  64'(we_cnt - we_base), 64'd0);
      chk("mr_r10",   regs[10], 64'd0);
      for (int k = 0; k < 5; k++) begin
         issue(mk(5'b11000, 5'd11, 5'd1, 5'd2, 12'd0));
         tick(); tick(); tick();
      end
      chk("wrap_ret", 64'(retired), 64'd1);
      chk("wrap_we",  64'(we_cnt - we_base), 64'd5);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
